instr_fetch_mem: RTL and testbench

//  Parametrised, loadable instruction memory for the IF stage. Byte-addressed PC in, one instruction
//  out one cycle later, with valid, stall-hold and fault flags. Program image is written at run time

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instr_ram_1r1w.sv | 33 +++
 rtl/instr_fetch_mem.sv | 138 +++++++++++++
 tb/tb_instr_fetch_mem.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch memory: NOP encoding, FSM states, PC-to-index helper.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

  // Byte PC to word index; callers truncate to their own index width.
  function automatic logic [31:0] idx_of(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction

endpackage

// File: rtl/instr_ram_1r1w.sv
// WIDTH x DEPTH storage with one synchronous write port and one registered read port.
// Read-during-write to the same word returns the old contents; the caller bypasses.
module instr_ram_1r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the read register is reset; the array is cleared by the owner's sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable IF-stage instruction memory: 1-cycle fetch with stall hold, fault flags and load bypass.
// state    | meaning
// ST_CLEAR | sweeping NOP into every word after reset; fetch and load ignored
// ST_RUN   | fetch and load accepted until the next reset
module instr_fetch_mem
  import fetch_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 128,
  parameter  int PC_W  = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic             fetch_stall,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  instr_pc,
  output logic             fault_align,
  output logic             fault_range,
  output logic             ready,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ack
);

  fetch_state_e     state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

  logic             run;
  logic             accept;
  logic [IDX_W-1:0] fetch_idx;
  logic             pc_misaligned;
  logic             pc_out_of_range;
  logic             ld_hit;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  logic             valid_q;
  logic [PC_W-1:0]  pc_q;
  logic             fa_q;
  logic             fr_q;
  logic             byp_q;
  logic [WIDTH-1:0] byp_data_q;
  logic             ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + IDX_W'(1);
      if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  assign run       = (state_q == ST_RUN);
  assign accept    = run & fetch_req & ~fetch_stall;
  assign fetch_idx = IDX_W'(idx_of(32'(fetch_pc)));

  assign pc_misaligned   = (fetch_pc[1:0] != 2'b00);
  assign pc_out_of_range = ~pc_misaligned && ((fetch_pc >> (IDX_W + 2)) != '0);
  assign ld_hit          = ld_en && (ld_addr == fetch_idx);

  // The clear sweep owns the write port until RUN; loads are dropped meanwhile.
  assign ram_we    = run ? ld_en   : 1'b1;
  assign ram_waddr = run ? ld_addr : clr_cnt_q;
  assign ram_wdata = run ? ld_data : WIDTH'(NOP_INSTR);

  instr_ram_1r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (accept),
    .raddr_i (fetch_idx),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      fa_q       <= 1'b0;
      fr_q       <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= run & ld_en;
      if (run && !fetch_stall) begin
        valid_q <= fetch_req;
        if (fetch_req) begin
          pc_q       <= fetch_pc;
          fa_q       <= pc_misaligned;
          fr_q       <= pc_out_of_range;
          byp_q      <= ld_hit;
          byp_data_q <= ld_data;
        end
      end
    end
  end

  // Everything feeding this mux is held during a stall, so instr holds too.
  always_comb begin
    instr = ram_rdata;
    if (fa_q || fr_q) instr = WIDTH'(NOP_INSTR);
    else if (byp_q)   instr = byp_data_q;
  end

  assign instr_valid = valid_q;
  assign instr_pc    = pc_q;
  assign fault_align = fa_q;
  assign fault_range = fr_q;
  assign ready       = run;
  assign ld_ack      = ack_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed and randomized checks of instr_fetch_mem against a word-array reference model.
module tb_instr_fetch_mem;

  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int PC_W  = 32;
  localparam int IDX_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_req;
  logic [PC_W-1:0]  fetch_pc;
  logic             fetch_stall;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic [PC_W-1:0]  instr_pc;
  logic             fault_align;
  logic             fault_range;
  logic             ready;
  logic             ld_en;
  logic [IDX_W-1:0] ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ack;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_sweep;
  logic             m_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_instr;
  logic [PC_W-1:0]  m_pc;
  logic             m_fa;
  logic             m_fr;
  logic             m_ack;

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_stall (fetch_stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .fault_align (fault_align),
    .fault_range (fault_range),
    .ready       (ready),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ack      (ld_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sweep = 0;
    m_ready = 1'b0;
    m_valid = 1'b0;
    m_instr = '0;
    m_pc    = '0;
    m_fa    = 1'b0;
    m_fr    = 1'b0;
    m_ack   = 1'b0;
  endtask

  // One clock: sample inputs, advance model at the edge, compare 1 ns later.
  task automatic cycle();
    logic             s_req, s_stall, s_ld;
    logic [PC_W-1:0]  s_pc;
    logic [IDX_W-1:0] s_addr;
    logic [WIDTH-1:0] s_data;
    int               idx;
    logic             mis, oor;
    s_req = fetch_req; s_pc = fetch_pc; s_stall = fetch_stall;
    s_ld = ld_en; s_addr = ld_addr; s_data = ld_data;
    @(posedge clk);
    if (!m_ready) begin
      m_sweep++;
      if (m_sweep == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      m_ack = s_ld;
      if (!s_stall) begin
        m_valid = s_req;
        if (s_req) begin
          idx = int'((s_pc / 4) % DEPTH);
          mis = (s_pc % 4) != 0;
          oor = !mis && (s_pc >= DEPTH * 4);
          m_pc = s_pc;
          m_fa = mis;
          m_fr = oor;
          if (mis || oor)                   m_instr = '0;
          else if (s_ld && s_addr == idx)   m_instr = s_data;
          else                              m_instr = m_mem[idx];
        end
      end
      if (s_ld) m_mem[s_addr] = s_data;
    end
    #1;
    chk("ready", 64'(ready), 64'(m_ready));
    chk("valid", 64'(instr_valid), 64'(m_valid));
    chk("ld_ack", 64'(ld_ack), 64'(m_ack));
    if (m_valid) begin
      chk("instr", 64'(instr), 64'(m_instr));
      chk("instr_pc", 64'(instr_pc), 64'(m_pc));
      chk("fault_align", 64'(fault_align), 64'(m_fa));
      chk("fault_range", 64'(fault_range), 64'(m_fr));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_pc", 64'(instr_pc), 64'h0);
    chk("rst_faults", 64'({fault_align, fault_range}), 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_ack", 64'(ld_ack), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_idle();
    fetch_req = 1'b0; fetch_pc = '0; fetch_stall = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  initial begin
    int mode;
    rst = 1'b1;
    set_idle();
    #3;

    // 1: sweep length and first fetch
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle();
      chk("sweep_ready", 64'(ready), 64'(i == DEPTH));
    end
    fetch_req = 1'b1; fetch_pc = 32'h40;
    cycle();
    chk("t1_instr", 64'(instr), 64'h0);
    chk("t1_valid", 64'(instr_valid), 64'h1);

    // 2: load then fetch
    fetch_req = 1'b0;
    ld_en = 1'b1; ld_addr = 7'd3; ld_data = 32'h0822_0800;
    cycle();
    chk("t2_ack", 64'(ld_ack), 64'h1);
    ld_en = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'h0C;
    cycle();
    chk("t2_instr", 64'(instr), 64'h0822_0800);
    chk("t2_pc", 64'(instr_pc), 64'h0C);
    chk("t2_ack_drop", 64'(ld_ack), 64'h0);

    // 3: stall holds the 0x0C result, re-presented 0x10 lands after the stall
    fetch_stall = 1'b1; fetch_pc = 32'h10;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_hold_instr", 64'(instr), 64'h0822_0800);
      chk("t3_hold_pc", 64'(instr_pc), 64'h0C);
    end
    fetch_stall = 1'b0;
    cycle();
    chk("t3_pc", 64'(instr_pc), 64'h10);
    chk("t3_valid", 64'(instr_valid), 64'h1);

    // 4: faults
    fetch_pc = 32'h200;
    cycle();
    chk("t4_range", 64'({fault_range, fault_align}), 64'h2);
    chk("t4_range_nop", 64'(instr), 64'h0);
    fetch_pc = 32'h0E;
    cycle();
    chk("t4_align", 64'({fault_range, fault_align}), 64'h1);
    chk("t4_align_nop", 64'(instr), 64'h0);
    fetch_pc = 32'h202;
    cycle();
    chk("t4_align_prio", 64'({fault_range, fault_align}), 64'h1);

    // 5: same-cycle load and fetch of one word
    fetch_pc = 32'h14;
    ld_en = 1'b1; ld_addr = 7'd5; ld_data = 32'hA5A5_0001;
    cycle();
    chk("t5_bypass", 64'(instr), 64'hA5A5_0001);
    set_idle();

    // 6: reset mid-sweep, loads ignored during the sweep
    do_reset();
    for (int i = 0; i < 60; i++) cycle();
    do_reset();
    ld_en = 1'b1; ld_addr = 7'd7; ld_data = 32'hDEAD_BEEF;
    for (int i = 1; i <= DEPTH; i++) begin
      if (i == 20) ld_en = 1'b0;
      cycle();
      chk("t6_ready", 64'(ready), 64'(i == DEPTH));
      if (i < 20) chk("t6_no_ack", 64'(ld_ack), 64'h0);
    end
    fetch_req = 1'b1; fetch_pc = 32'h1C;
    cycle();
    chk("t6_word_cleared", 64'(instr), 64'h0);
    fetch_pc = 32'h0C;
    cycle();
    chk("t6_old_load_cleared", 64'(instr), 64'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      mode = int'($urandom_range(0, 9));
      fetch_req   = ($urandom_range(0, 9) < 7);
      fetch_stall = ($urandom_range(0, 3) == 0);
      if (mode <= 6)      fetch_pc = {23'h0, 7'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (mode == 7) fetch_pc = {23'h0, 7'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else if (mode == 8) fetch_pc = $urandom | 32'h200;
      else                fetch_pc = 32'($urandom_range(0, 16'hFFFF));
      ld_en   = ($urandom_range(0, 9) < 3);
      ld_addr = ($urandom_range(0, 1) == 0) ? fetch_pc[IDX_W+1:2] : 7'($urandom_range(0, DEPTH - 1));
      ld_data = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
